shift_reg_seq: RTL and testbench

- Parametrised universal shift register: shifts left/right with serial fill, rotates, does arithmetic shift right, and loads in parallel.
- Adds a multi-step burst sequencer. One `start` command applies the same operation N times, one step per clock, with busy/done status.
- Sits in datapaths that need variable-distance shifts or serialisation without an external counter.

---
 rtl/shift_reg_seq.sv | 153 +++++++++++++++
 tb/tb_shift_reg_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// Universal shift register: shift, rotate, arithmetic shift and parallel load,
// with a burst sequencer that repeats one operation N times, one step per clock.
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             d_l,
    input  logic             d_r,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_LOAD = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ser_q, ser_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   step_out;
    logic               step_ser;
    logic               req_hold;

    // A burst replays its latched mode; a single step uses the live mode.
    assign step_mode = (state_q == RUN) ? mode_q : mode;
    assign req_hold  = (mode == 3'd0) || (mode == 3'd7);

    always_comb begin
        step_out = out_q;
        step_ser = ser_q;
        unique case (step_mode)
            M_SHL: begin
                step_out = {out_q[WIDTH-2:0], d_l};
                step_ser = out_q[WIDTH-1];
            end
            M_SHR: begin
                step_out = {d_r, out_q[WIDTH-1:1]};
                step_ser = out_q[0];
            end
            M_ROL: begin
                step_out = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                step_ser = out_q[WIDTH-1];
            end
            M_ROR: begin
                step_out = {out_q[0], out_q[WIDTH-1:1]};
                step_ser = out_q[0];
            end
            M_LOAD: begin
                step_out = par_in;
            end
            M_ASR: begin
                step_out = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                step_ser = out_q[0];
            end
            default: begin
                step_out = out_q;
                step_ser = ser_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((amount != '0) && !req_hold) begin
                        mode_d  = mode;
                        cnt_d   = amount;
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    out_d = step_out;
                    ser_d = step_ser;
                end
            end
            RUN: begin
                if (en) begin
                    out_d = step_out;
                    ser_d = step_ser;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            out_q   <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out     = out_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed and random checks of shift_reg_seq against an arithmetic
// model of the register and a remaining-steps model of the burst.
module tb_shift_reg_seq;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst, en, d_l, d_r, start;
    logic [2:0]   mode;
    logic [W-1:0] par_in;
    logic [C-1:0] amount;
    logic [W-1:0] out;
    logic         ser_out, busy, done;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] m_out;
    logic         m_ser, m_busy, m_done;
    int           m_rem;
    logic [2:0]   m_mode;

    shift_reg_seq #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .d_l(d_l), .d_r(d_r), .par_in(par_in),
        .start(start), .amount(amount),
        .out(out), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_op(input logic [2:0] op);
        int v;
        v = int'(m_out);
        case (op)
            3'd1: begin
                m_ser = (v >= 128);
                m_out = W'((v * 2 + int'(d_l)) % 256);
            end
            3'd2: begin
                m_ser = v[0];
                m_out = W'(v / 2 + (d_r ? 128 : 0));
            end
            3'd3: begin
                m_ser = (v >= 128);
                m_out = W'((v * 2) % 256 + v / 128);
            end
            3'd4: begin
                m_ser = v[0];
                m_out = W'(v / 2 + (v % 2) * 128);
            end
            3'd5: m_out = par_in;
            3'd6: begin
                m_ser = v[0];
                m_out = W'(v / 2 + ((v >= 128) ? 128 : 0));
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!rst) begin
            m_out = '0; m_ser = 1'b0; m_busy = 1'b0; m_rem = 0; m_mode = '0;
        end else if (m_busy) begin
            if (en) begin
                apply_op(m_mode);
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (start) begin
            if (amount != 0 && mode >= 3'd1 && mode <= 3'd6) begin
                m_busy = 1'b1; m_rem = int'(amount); m_mode = mode;
            end else begin
                m_done = 1'b1;
            end
        end else if (en) begin
            apply_op(mode);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("out", 32'(out), 32'(m_out));
        check("ser_out", 32'(ser_out), 32'(m_ser));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic load(input logic [W-1:0] v);
        start = 1'b0; en = 1'b1; mode = 3'd5; par_in = v;
        cycle();
    endtask

    int dones;

    initial begin
        rst = 1'b0; en = 1'b0; d_l = 1'b0; d_r = 1'b0; start = 1'b0;
        mode = '0; par_in = '0; amount = '0;
        m_out = '0; m_ser = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_rem = 0; m_mode = '0;
        #2;
        cycle(); cycle();
        rst = 1'b1;
        load(8'h3C);
        mode = 3'd1; start = 1'b1; amount = 4'd5;
        cycle(); start = 1'b0; cycle();
        rst = 1'b0; cycle(); cycle();
        check("rst_out", 32'(out), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ser", 32'(ser_out), 32'h0);
        rst = 1'b1;

        load(8'hA5);
        check("load_a5", 32'(out), 32'hA5);
        mode = 3'd1; d_l = 1'b1; cycle();
        check("shl_out", 32'(out), 32'h4B);
        check("shl_ser", 32'(ser_out), 32'h1);
        d_l = 1'b0;

        load(8'h81);
        mode = 3'd3; amount = 4'd3; start = 1'b1; cycle();
        check("rol_busy0", 32'(busy), 32'h1);
        start = 1'b0; mode = 3'd0;
        cycle(); cycle(); cycle();
        check("rol_out", 32'(out), 32'h0C);
        check("rol_ser", 32'(ser_out), 32'h0);
        check("rol_done", 32'(done), 32'h1);
        cycle();
        check("rol_done_clr", 32'(done), 32'h0);

        load(8'h80);
        mode = 3'd6; amount = 4'd4; start = 1'b1; cycle();
        start = 1'b0; cycle(); cycle();
        en = 1'b0; cycle(); cycle();
        check("asr_pause_out", 32'(out), 32'hE0);
        check("asr_pause_busy", 32'(busy), 32'h1);
        en = 1'b1; cycle();
        check("asr_no_done_yet", 32'(done), 32'h0);
        cycle();
        check("asr_out", 32'(out), 32'hF8);
        check("asr_done", 32'(done), 32'h1);

        mode = 3'd1; amount = 4'd0; start = 1'b1; cycle();
        check("amt0_done", 32'(done), 32'h1);
        check("amt0_out", 32'(out), 32'hF8);
        mode = 3'd0; amount = 4'd5; cycle();
        check("hold_done", 32'(done), 32'h1);
        check("hold_busy", 32'(busy), 32'h0);
        start = 1'b0; cycle();

        mode = 3'd4; amount = 4'd3; start = 1'b1; cycle();
        dones = 0;
        start = 1'b0; cycle();
        start = 1'b1; cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            cycle();
        end
        if (done) dones++;
        check("run_start_drop", 32'(dones), 32'd1);

        load(8'hF0);
        mode = 3'd2; amount = 4'd7; d_r = 1'b1; start = 1'b1; cycle();
        start = 1'b0; cycle(); cycle(); cycle();
        rst = 1'b0; cycle();
        check("abort_out", 32'(out), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        rst = 1'b1; cycle();
        check("abort_no_done", 32'(done), 32'h0);
        d_r = 1'b0;
        load(8'h01);
        mode = 3'd4; amount = 4'd1; start = 1'b1; cycle();
        start = 1'b0; cycle();
        check("ror_out", 32'(out), 32'h80);
        check("ror_done", 32'(done), 32'h1);

        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 40) != 0);
            en     = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 7) == 0);
            mode   = 3'($urandom_range(0, 7));
            amount = C'($urandom_range(0, 15));
            d_l    = 1'($urandom);
            d_r    = 1'($urandom);
            par_in = W'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
